// File: rtl/ffapuf_eval_ctrl.sv
// ---------------------------------------------------------------------------
// ffapuf_eval_ctrl
//   Challenge generator and response evaluator for one feed-forward arbiter
//   PUF line. A 32-bit LFSR supplies the challenge. Each evaluation runs
//   clear -> arm -> fire (settle) -> sample. Each challenge is evaluated VOTES
//   times and majority-voted into one bit. RESP_BITS voted bits are packed
//   into a word that is handed downstream with a valid/ready handshake.
//
// Ports
//   clk         system clock
//   clr         synchronous active-low reset
//   start       request one response word (honoured in IDLE only)
//   seed_load   load seed into the LFSR (honoured in IDLE only)
//   seed        LFSR load value; zero is replaced by SEED
//   puf_clr     active-high clear to the PUF line slices
//   puf_launch  launch edge into the PUF line
//   puf_c       challenge to the PUF line (current LFSR value)
//   puf_r       raw PUF response, asynchronous to clk
//   resp        voted response word, bit k = k-th voted bit
//   resp_chal   challenge used for resp[0]
//   resp_valid  resp / resp_chal valid
//   resp_ready  downstream accepts the word
//   busy        high from start acceptance until the handshake completes
// ---------------------------------------------------------------------------
module ffapuf_eval_ctrl #(
  parameter int          RESP_BITS = 8,
  parameter int          VOTES     = 5,
  parameter int          CLR_CYC   = 2,
  parameter int          SETTLE    = 4,
  parameter logic [31:0] SEED      = 32'hACE1_2345
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 seed_load,
  input  logic [31:0]          seed,
  output logic                 puf_clr,
  output logic                 puf_launch,
  output logic [31:0]          puf_c,
  input  logic                 puf_r,
  output logic [RESP_BITS-1:0] resp,
  output logic [31:0]          resp_chal,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 busy
);

  // One phase counter serves both the CLEAR and FIRE dwell times.
  localparam int PH_MAX = (CLR_CYC > SETTLE) ? CLR_CYC : SETTLE;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int VOTE_W = $clog2(VOTES + 1);
  localparam int BIT_W  = $clog2(RESP_BITS + 1);

  localparam logic [PH_W-1:0]   CLR_LAST  = PH_W'(CLR_CYC - 1);
  localparam logic [PH_W-1:0]   SET_LAST  = PH_W'(SETTLE - 1);
  localparam logic [VOTE_W-1:0] VOTE_LAST = VOTE_W'(VOTES - 1);
  localparam logic [VOTE_W-1:0] HALF      = VOTE_W'(VOTES / 2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(RESP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ARM,
    S_FIRE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_sync1;
  logic                r_sync2;
  logic [31:0]         r_lfsr;
  logic [PH_W-1:0]     r_phase;
  logic [VOTE_W-1:0]   r_votes;
  logic [VOTE_W-1:0]   r_ones;
  logic [BIT_W-1:0]    r_bit_idx;
  logic [RESP_BITS-1:0] r_resp;
  logic [31:0]         r_resp_chal;

  logic [VOTE_W-1:0]   w_ones_sum;
  logic                w_last_vote;
  logic                w_last_bit;
  logic                w_vote_bit;
  logic [31:0]         w_seed_val;
  logic [31:0]         w_lfsr_next;

  // The vote decision includes the sample taken in the current SAMPLE cycle.
  assign w_ones_sum  = r_ones + VOTE_W'(r_sync2);
  assign w_last_vote = (r_votes == VOTE_LAST);
  assign w_last_bit  = (r_bit_idx == BIT_LAST);
  assign w_vote_bit  = (w_ones_sum > HALF);
  // An all-zero LFSR would lock up, so a zero seed falls back to SEED.
  assign w_seed_val  = (seed == 32'd0) ? SEED : seed;
  assign w_lfsr_next = {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};

  assign puf_c      = r_lfsr;
  assign resp       = r_resp;
  assign resp_chal  = r_resp_chal;
  assign resp_valid = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);

  // Next-state and PUF line controls
  always_comb begin
    w_next     = r_state;
    puf_clr    = 1'b1;
    puf_launch = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        if (r_phase == CLR_LAST) w_next = S_ARM;
      end
      S_ARM: begin
        puf_clr = 1'b0;
        w_next  = S_FIRE;
      end
      S_FIRE: begin
        puf_clr    = 1'b0;
        puf_launch = 1'b1;
        if (r_phase == SET_LAST) w_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        puf_clr    = 1'b0;
        puf_launch = 1'b1;
        if (w_last_vote && w_last_bit) w_next = S_DONE;
        else                           w_next = S_CLEAR;
      end
      S_DONE: begin
        if (resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, synchronizer, counters, LFSR and response registers
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state     <= S_IDLE;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_lfsr      <= SEED;
      r_phase     <= '0;
      r_votes     <= '0;
      r_ones      <= '0;
      r_bit_idx   <= '0;
      r_resp      <= '0;
      r_resp_chal <= '0;
    end else begin
      r_sync1 <= puf_r;
      r_sync2 <= r_sync1;
      r_state <= w_next;

      if (w_next != r_state)
        r_phase <= '0;
      else if (r_state == S_CLEAR || r_state == S_FIRE)
        r_phase <= r_phase + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (seed_load) r_lfsr <= w_seed_val;
          if (start) begin
            // A same-cycle seed load defines the first challenge.
            r_resp_chal <= seed_load ? w_seed_val : r_lfsr;
            r_resp      <= '0;
            r_votes     <= '0;
            r_ones      <= '0;
            r_bit_idx   <= '0;
          end
        end
        S_SAMPLE: begin
          if (w_last_vote) begin
            for (int k = 0; k < RESP_BITS; k++)
              if (r_bit_idx == BIT_W'(k)) r_resp[k] <= w_vote_bit;
            r_ones    <= '0;
            r_votes   <= '0;
            r_lfsr    <= w_lfsr_next;
            r_bit_idx <= r_bit_idx + 1'b1;
          end else begin
            r_ones  <= w_ones_sum;
            r_votes <= r_votes + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ffapuf_eval_ctrl.sv
module tb_ffapuf_eval_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        seed_load;
  logic [31:0] seed;
  logic        puf_clr;
  logic        puf_launch;
  logic [31:0] puf_c;
  logic        puf_r = 1'b0;
  logic [7:0]  resp;
  logic [31:0] resp_chal;
  logic        resp_valid;
  logic        resp_ready;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // PUF model: 0 = constant 0, 1 = constant 1, 2 = majority pattern
  int mode     = 0;
  int eval_idx = 0;

  ffapuf_eval_ctrl dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .seed_load  (seed_load),
    .seed       (seed),
    .puf_clr    (puf_clr),
    .puf_launch (puf_launch),
    .puf_c      (puf_c),
    .puf_r      (puf_r),
    .resp       (resp),
    .resp_chal  (resp_chal),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // New response value per launch; even bits get 3 of 5 ones, odd bits 2 of 5.
  always @(posedge puf_launch) begin
    int b;
    int v;
    b = eval_idx / 5;
    v = eval_idx % 5;
    case (mode)
      0:       puf_r = 1'b0;
      1:       puf_r = 1'b1;
      default: puf_r = ((b % 2) == 0) ? (v < 3) : (v < 2);
    endcase
    eval_idx++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start = (i != 1);
      tick();
    end
    start = 1'b0;
    n_checks++;
    if (puf_clr !== 1'b1) begin n_fail++; $display("FAIL reset_puf_clr: got %b want 1", puf_clr); end
    n_checks++;
    if (puf_launch !== 1'b0) begin n_fail++; $display("FAIL reset_puf_launch: got %b want 0", puf_launch); end
    n_checks++;
    if (puf_c !== 32'hACE12345) begin n_fail++; $display("FAIL reset_puf_c: got %h want ACE12345", puf_c); end
    n_checks++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (resp !== 8'h00 || resp_chal !== 32'h0) begin
      n_fail++; $display("FAIL reset_resp: got %h/%h want 00/00000000", resp, resp_chal);
    end
    clr = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_start_ignored: busy %b want 0", busy); end
  endtask

  task automatic test_const_one();
    int cyc;
    logic [7:0] exp_clr;
    logic [7:0] exp_launch;
    exp_clr    = 8'b0000_0011;  // bit i = cycle i after start edge
    exp_launch = 8'b1111_1000;
    mode = 1;
    pulse_start();
    cyc = 0;
    while (resp_valid !== 1'b1 && cyc < 1000) begin
      if (cyc < 8) begin
        n_checks++;
        if (puf_clr !== exp_clr[cyc] || puf_launch !== exp_launch[cyc]) begin
          n_fail++;
          $display("FAIL eval_phase cyc%0d: clr/launch %b%b want %b%b", cyc, puf_clr, puf_launch,
                   exp_clr[cyc], exp_launch[cyc]);
        end
      end
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc + 1 != 321) begin n_fail++; $display("FAIL const1_latency: got %0d want 321", cyc + 1); end
    n_checks++;
    if (resp !== 8'hFF) begin n_fail++; $display("FAIL const1_resp: got %h want FF", resp); end
    n_checks++;
    if (resp_chal !== 32'hACE12345) begin n_fail++; $display("FAIL const1_chal: got %h want ACE12345", resp_chal); end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL const1_handshake: valid/busy %b%b want 00", resp_valid, busy);
    end
  endtask

  task automatic test_majority();
    int cyc;
    mode = 2;
    eval_idx = 0;
    pulse_start();
    cyc = 0;
    while (resp_valid !== 1'b1 && cyc < 1000) begin tick(); cyc++; end
    n_checks++;
    if (cyc != 320) begin n_fail++; $display("FAIL majority_timeout: got %0d want 320", cyc); end
    n_checks++;
    if (resp !== 8'h55) begin n_fail++; $display("FAIL majority_resp: got %h want 55", resp); end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_lfsr();
    int cyc;
    mode = 0;
    seed = 32'h1;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    n_checks++;
    if (puf_c !== 32'h1) begin n_fail++; $display("FAIL lfsr_load: got %h want 00000001", puf_c); end
    pulse_start();
    cyc = 0;
    while (resp_valid !== 1'b1 && cyc < 1000) begin
      if (cyc == 39) begin
        n_checks++;
        if (puf_c !== 32'h1) begin n_fail++; $display("FAIL lfsr_hold: got %h want 00000001", puf_c); end
      end
      if (cyc == 40) begin
        n_checks++;
        if (puf_c !== 32'h3) begin n_fail++; $display("FAIL lfsr_step1: got %h want 00000003", puf_c); end
      end
      if (cyc == 80) begin
        n_checks++;
        if (puf_c !== 32'h6) begin n_fail++; $display("FAIL lfsr_step2: got %h want 00000006", puf_c); end
      end
      tick();
      cyc++;
    end
    n_checks++;
    if (resp_chal !== 32'h1 || resp !== 8'h00) begin
      n_fail++; $display("FAIL lfsr_result: got %h/%h want 00/00000001", resp, resp_chal);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    // Zero seed loaded in the same cycle as start
    seed = 32'h0;
    seed_load = 1'b1;
    start = 1'b1;
    tick();
    seed_load = 1'b0;
    start = 1'b0;
    n_checks++;
    if (puf_c !== 32'hACE12345 || resp_chal !== 32'hACE12345) begin
      n_fail++; $display("FAIL lfsr_zero_seed: got %h/%h want ACE12345", puf_c, resp_chal);
    end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL lfsr_same_cycle_start: busy %b want 1", busy); end
    cyc = 0;
    while (resp_valid !== 1'b1 && cyc < 1000) begin tick(); cyc++; end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int cyc;
    mode = 1;
    pulse_start();
    cyc = 0;
    while (resp_valid !== 1'b1 && cyc < 1000) begin tick(); cyc++; end
    for (int i = 0; i < 50; i++) begin
      start = (i == 10);
      tick();
      n_checks++;
      if (resp_valid !== 1'b1 || busy !== 1'b1 || resp !== 8'hFF) begin
        n_fail++;
        $display("FAIL bp_hold cyc%0d: valid/busy/resp %b%b/%h want 11/FF", i, resp_valid, busy, resp);
      end
    end
    start = 1'b0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || puf_clr !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: valid/busy/clr %b%b%b want 001", resp_valid, busy, puf_clr);
    end
    pulse_start();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_restart: busy %b want 1", busy); end
    cyc = 0;
    while (resp_valid !== 1'b1 && cyc < 1000) begin tick(); cyc++; end
    n_checks++;
    if (resp !== 8'hFF) begin n_fail++; $display("FAIL bp_restart_resp: got %h want FF", resp); end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    int cyc;
    mode = 1;
    pulse_start();
    for (int i = 0; i < 124; i++) tick();
    n_checks++;
    if (puf_launch !== 1'b1 || puf_clr !== 1'b0) begin
      n_fail++; $display("FAIL mid_fire_bit3: clr/launch %b%b want 01", puf_clr, puf_launch);
    end
    clr = 1'b0;
    tick();
    clr = 1'b1;
    n_checks++;
    if (puf_clr !== 1'b1 || puf_launch !== 1'b0 || busy !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_ctrl: clr/launch/busy/valid %b%b%b%b want 1000", puf_clr, puf_launch, busy,
               resp_valid);
    end
    n_checks++;
    if (puf_c !== 32'hACE12345) begin n_fail++; $display("FAIL mid_reset_lfsr: got %h want ACE12345", puf_c); end
    n_checks++;
    if (resp !== 8'h00 || resp_chal !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset_resp: got %h/%h want 00/00000000", resp, resp_chal);
    end
    pulse_start();
    cyc = 0;
    while (resp_valid !== 1'b1 && cyc < 1000) begin tick(); cyc++; end
    n_checks++;
    if (cyc + 1 != 321) begin n_fail++; $display("FAIL mid_rerun_latency: got %0d want 321", cyc + 1); end
    n_checks++;
    if (resp !== 8'hFF || resp_chal !== 32'hACE12345) begin
      n_fail++; $display("FAIL mid_rerun_resp: got %h/%h want FF/ACE12345", resp, resp_chal);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    clr        = 1'b0;
    start      = 1'b0;
    seed_load  = 1'b0;
    seed       = 32'h0;
    resp_ready = 1'b0;
    test_reset();
    test_const_one();
    test_majority();
    test_lfsr();
    test_backpressure();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
